// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, private asynchronous-read instruction
// memory and squash logic. Optional fault output enabled by IF_STAGE_FETCH_FAULT_EN.

module if_stage_imem #(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic [29:0] i_word_idx,
    output logic [31:0] o_rdata
);
    localparam int unsigned AW       = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_W  = 32'(IMEM_DEPTH);

    // Loaded only from outside (hierarchical preload); there is no write port.
    // NOTE: memory arrays are never reset, so reset leaves the contents intact.
    logic [31:0] mem [0:IMEM_DEPTH-1];

    logic w_in_range;

    assign w_in_range = ({2'b00, i_word_idx} < DEPTH_W);

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        o_rdata = NOP_WORD;
        if (w_in_range) begin
            o_rdata = mem[i_word_idx[AW-1:0]];
        end
    end
endmodule

module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out,
`ifdef IF_STAGE_FETCH_FAULT_EN
    output logic        fetch_fault,
`endif
    output logic [31:0] instruction_out
);
    logic [31:0] pc_q;
    logic [31:0] w_mem_word;
    logic        w_squash;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (flush || !stall) begin
            pc_q <= pc_in;
        end
    end

    if_stage_imem #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .NOP_WORD   (NOP_WORD)
    ) imem_inst (
        .i_word_idx (pc_q[31:2]),
        .o_rdata    (w_mem_word)
    );

`ifdef IF_STAGE_FETCH_FAULT_EN
    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned   = (pc_q[1:0] != 2'b00);
    assign w_out_of_range = ({2'b00, pc_q[31:2]} >= DEPTH_W);
    // A flushed fetch is discarded anyway, so it never reports a fault.
    assign fetch_fault    = !flush && (w_misaligned || w_out_of_range);
    assign w_squash       = flush || fetch_fault;
`else
    assign w_squash       = flush;
`endif

    assign pc_out          = pc_q;
    assign instruction_out = w_squash ? NOP_WORD : w_mem_word;
endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: reset, sequential fetch, stall,
// flush priority, memory boundary and asynchronous reset mid-run.

module tb_if_stage;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
`ifdef IF_STAGE_FETCH_FAULT_EN
    logic        fetch_fault;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    if_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (DEPTH),
        .NOP_WORD   (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .pc_in           (pc_in),
        .pc_out          (pc_out),
`ifdef IF_STAGE_FETCH_FAULT_EN
        .fetch_fault     (fetch_fault),
`endif
        .instruction_out (instruction_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preload pattern: word 0 is addi $t0,$0,5, last word is a marker, the rest encode their index.
    function automatic logic [31:0] exp_word(input int unsigned idx);
        if (idx == 0)              return 32'h2008_0005;
        else if (idx == DEPTH - 1) return 32'hDEAD_BEEF;
        else                       return 32'hA000_0000 | 32'(idx);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            dut.imem_inst.mem[i] = exp_word(i);
        end
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        pc_in = 32'h0000_1234;

        // Edges under reset must not load pc_in.
        tick();
        tick();
        check("reset_pc", pc_out, 32'h0);
        check("reset_instr", instruction_out, 32'h2008_0005);

        // Release mid-cycle; nothing moves until the next edge.
        pc_in = 32'h4;
        #2;
        rst = 1'b0;
        #1;
        check("rst_release_pc", pc_out, 32'h0);
        check("rst_release_instr", instruction_out, 32'h2008_0005);

        for (int k = 1; k <= 25; k++) begin
            pc_in = 32'(4 * k);
            tick();
            check($sformatf("seq_pc_%0d", k), pc_out, 32'(4 * k));
            check($sformatf("seq_instr_%0d", k), instruction_out, exp_word(k));
        end

        // Stall holds PC for three edges.
        pc_in = 32'h10;
        tick();
        check("pre_stall_pc", pc_out, 32'h10);
        stall = 1'b1;
        pc_in = 32'h14;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall_pc_%0d", k), pc_out, 32'h10);
            check($sformatf("stall_instr_%0d", k), instruction_out, exp_word(4));
        end
        stall = 1'b0;
        tick();
        check("unstall_pc", pc_out, 32'h14);
        check("unstall_instr", instruction_out, exp_word(5));

        // Flush beats stall and squashes combinationally.
        pc_in = 32'h20;
        tick();
        check("pre_flush_pc", pc_out, 32'h20);
        stall = 1'b1;
        flush = 1'b1;
        pc_in = 32'h80;
        #1;
        check("flush_instr_now", instruction_out, NOP);
        check("flush_pc_now", pc_out, 32'h20);
        tick();
        check("flush_pc_loaded", pc_out, 32'h80);
        check("flush_instr_held", instruction_out, NOP);
        flush = 1'b0;
        stall = 1'b0;
        #1;
        check("post_flush_instr", instruction_out, exp_word(32));

        // Misaligned PC.
        pc_in = 32'h81;
        tick();
        check("misaligned_pc", pc_out, 32'h81);
`ifdef IF_STAGE_FETCH_FAULT_EN
        check("misaligned_instr", instruction_out, NOP);
        check("misaligned_fault", 32'(fetch_fault), 32'h1);
`else
        check("misaligned_instr", instruction_out, exp_word(32));
`endif

        // Memory boundary: last word, then one past the end, then far past.
        pc_in = 32'(4 * (DEPTH - 1));
        tick();
        check("last_word", instruction_out, 32'hDEAD_BEEF);
`ifdef IF_STAGE_FETCH_FAULT_EN
        check("last_word_fault", 32'(fetch_fault), 32'h0);
`endif
        pc_in = 32'(4 * DEPTH);
        tick();
        check("past_end_pc", pc_out, 32'(4 * DEPTH));
        check("past_end_instr", instruction_out, NOP);
`ifdef IF_STAGE_FETCH_FAULT_EN
        check("past_end_fault", 32'(fetch_fault), 32'h1);
        flush = 1'b1;
        #1;
        check("flush_masks_fault", 32'(fetch_fault), 32'h0);
        flush = 1'b0;
`endif
        pc_in = 32'hFFFF_FFFC;
        tick();
        check("top_addr_instr", instruction_out, NOP);

        // Asynchronous reset between edges.
        pc_in = 32'h40;
        tick();
        check("pre_async_pc", pc_out, 32'h40);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", pc_out, 32'h0);
        check("async_rst_instr", instruction_out, 32'h2008_0005);
        tick();
        rst = 1'b0;
        check("async_rst_hold_pc", pc_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
